// File: rtl/chromatic_pwm.sv
// chromatic_pwm: shared PWM engine driving an RGB LED matrix, either from
// host-loaded static duties or from an autonomous six-segment hue sweep.
module chromatic_pwm #(
    parameter int N_LEDS       = 25,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 4,
    parameter int STEP_PERIODS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic [PWM_BITS-1:0] duty_r,
    input  logic [PWM_BITS-1:0] duty_g,
    input  logic [PWM_BITS-1:0] duty_b,
    input  logic                duty_load,
    input  logic [N_LEDS-1:0]   led_en,
    output logic [N_LEDS-1:0]   R,
    output logic [N_LEDS-1:0]   G,
    output logic [N_LEDS-1:0]   B,
    output logic                period_start,
    output logic [2:0]          hue_seg
);

    localparam logic [PWM_BITS-1:0] M = '1;
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);

    typedef enum logic [2:0] {
        SEG0 = 3'd0,
        SEG1 = 3'd1,
        SEG2 = 3'd2,
        SEG3 = 3'd3,
        SEG4 = 3'd4,
        SEG5 = 3'd5
    } seg_t;

    logic [PRE_W-1:0]    presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                wrap;

    logic [PWM_BITS-1:0] pend_r, pend_g, pend_b;
    logic [PWM_BITS-1:0] act_r, act_g, act_b;

    seg_t                seg, seg_nxt;
    logic [PWM_BITS-1:0] level, level_nxt;
    logic [STEP_W-1:0]   step_cnt, step_nxt;
    logic [PWM_BITS-1:0] sw_r, sw_g, sw_b;

    assign tick    = (presc == PRE_LAST);
    assign wrap    = tick && (pwm_cnt == M);
    assign hue_seg = seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + 1'b1;
            period_start <= wrap;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= '0;
            pend_g <= '0;
            pend_b <= '0;
        end else if (duty_load) begin
            pend_r <= duty_r;
            pend_g <= duty_g;
            pend_b <= duty_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg      <= SEG0;
            level    <= '0;
            step_cnt <= '0;
        end else begin
            seg      <= seg_nxt;
            level    <= level_nxt;
            step_cnt <= step_nxt;
        end
    end

    // Hue walk advances only on wraps seen in SWEEP; the colour is derived from
    // the post-step position so the new period starts with the stepped hue.
    always_comb begin
        seg_nxt   = seg;
        level_nxt = level;
        step_nxt  = step_cnt;
        if (wrap && mode) begin
            if (step_cnt == STEP_LAST) begin
                step_nxt = '0;
                if (level != M) begin
                    level_nxt = level + 1'b1;
                end else begin
                    level_nxt = '0;
                    case (seg)
                        SEG0:    seg_nxt = SEG1;
                        SEG1:    seg_nxt = SEG2;
                        SEG2:    seg_nxt = SEG3;
                        SEG3:    seg_nxt = SEG4;
                        SEG4:    seg_nxt = SEG5;
                        default: seg_nxt = SEG0;
                    endcase
                end
            end else begin
                step_nxt = step_cnt + 1'b1;
            end
        end

        sw_r = '0;
        sw_g = '0;
        sw_b = '0;
        case (seg_nxt)
            SEG0: begin sw_r = M;             sw_g = level_nxt;     sw_b = '0;            end
            SEG1: begin sw_r = M - level_nxt; sw_g = M;             sw_b = '0;            end
            SEG2: begin sw_r = '0;            sw_g = M;             sw_b = level_nxt;     end
            SEG3: begin sw_r = '0;            sw_g = M - level_nxt; sw_b = M;             end
            SEG4: begin sw_r = level_nxt;     sw_g = '0;            sw_b = M;             end
            SEG5: begin sw_r = M;             sw_g = '0;            sw_b = M - level_nxt; end
            default: begin sw_r = '0;         sw_g = '0;            sw_b = '0;            end
        endcase
    end

    // Active duties only change at a wrap, so a running period is never cut short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_r <= '0;
            act_g <= '0;
            act_b <= '0;
        end else if (wrap) begin
            if (mode) begin
                act_r <= sw_r;
                act_g <= sw_g;
                act_b <= sw_b;
            end else if (duty_load) begin
                act_r <= duty_r;
                act_g <= duty_g;
                act_b <= duty_b;
            end else begin
                act_r <= pend_r;
                act_g <= pend_g;
                act_b <= pend_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            R <= '0;
            G <= '0;
            B <= '0;
        end else begin
            R <= (pwm_cnt < act_r) ? led_en : '0;
            G <= (pwm_cnt < act_g) ? led_en : '0;
            B <= (pwm_cnt < act_b) ? led_en : '0;
        end
    end

endmodule
